// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// UART_ARB_HDR_EN adds the HDR state (owner-ID header byte before each frame).
package uart_arb_pkg;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_PAYLOAD_BITS = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
`ifdef UART_ARB_HDR_EN
    ST_HDR       = 3'd1,
`endif
    ST_FETCH     = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  grant,
  output logic             any_req
);

  logic [ID_W-1:0] idx;

  // Scan from farthest to nearest so the nearest candidate after last_grant wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(last_grant) + i) % N_REQ);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-locked round-robin arbiter feeding a single UART transmitter.
// UART_ARB_HDR_EN prefixes every frame with the owner ID byte.
//
// Handshake: a requester byte is taken on the rising edge where
// req_valid[k] & req_ready[k]; req_ready depends on registered state only.
// uart_tx_en is a one-cycle strobe; uart_tx_busy rises the cycle after it.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = DEF_N_REQ,
  parameter  int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  localparam int ID_W         = id_width(N_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          arb_busy,
  output arb_state_e                    dbg_state
);

  arb_state_e              state_q, state_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic [PAYLOAD_BITS-1:0] hold_data_q, hold_data_d;
  logic                    hold_last_q, hold_last_d;

  logic [ID_W-1:0]         arb_grant;
  logic                    arb_any;
  logic                    sel_valid;
  logic                    sel_last;
  logic [PAYLOAD_BITS-1:0] sel_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q == ID_W'(k)) begin
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
        sel_data  = req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_FETCH) begin
      for (int k = 0; k < N_REQ; k++) begin
        req_ready[k] = (grant_q == ID_W'(k));
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    uart_tx_en   = 1'b0;
    uart_tx_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any && !uart_tx_busy) begin
          grant_d = arb_grant;
`ifdef UART_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      // Clearing the held last flag routes WAIT_DONE back to FETCH.
      ST_HDR: begin
        if (!uart_tx_busy) begin
          uart_tx_en   = 1'b1;
          uart_tx_data = PAYLOAD_BITS'(grant_q);
          hold_last_d  = 1'b0;
          state_d      = ST_WAIT_ACK;
        end
      end
`endif
      ST_FETCH: begin
        if (sel_valid) begin
          hold_data_d = sel_data;
          hold_last_d = sel_last;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!uart_tx_busy) begin
          uart_tx_en   = 1'b1;
          uart_tx_data = hold_data_q;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (uart_tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (hold_last_q) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
    end
  end

  assign grant_id  = grant_q;
  assign arb_busy  = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a behavioural transmitter and a
// frame-level round-robin reference model (honours UART_ARB_HDR_EN).
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef UART_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic           clk;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           uart_tx_en;
  logic [W-1:0]   uart_tx_data;
  logic           uart_tx_busy;
  logic [1:0]     grant_id;
  logic           arb_busy;
  arb_state_e     dbg_state;

  uart_tx_arb #(.N_REQ(N), .PAYLOAD_BITS(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- behavioural transmitter ----------------
  int busy_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) busy_cnt <= 0;
    else if (uart_tx_en) busy_cnt <= int'($urandom_range(3, 40));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0);

  // ---------------- requester drivers ----------------
  logic [8:0] rq[N][$];
  logic [N-1:0] en;
  logic [N-1:0] acc;

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (en[k] && rq[k].size() > 0) begin
        req_valid[k]       = 1'b1;
        req_data[k*W +: W] = rq[k][0][7:0];
        req_last[k]        = rq[k][0][8];
      end else begin
        req_valid[k]       = 1'b0;
        req_data[k*W +: W] = '0;
        req_last[k]        = 1'b0;
      end
    end
  endtask

  always begin
    @(posedge clk);
    acc = req_valid & req_ready;
    #1;
    if (resetn) begin
      for (int k = 0; k < N; k++)
        if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    end
    drive();
  end

  // ---------------- scoreboard / monitor ----------------
  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [W-1:0] line_q[$];
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (resetn) begin
      if (uart_tx_en) begin
        line_q.push_back(uart_tx_data);
        strobes++;
      end
      assert (!(uart_tx_en && uart_tx_busy)) else begin
        errors++;
        $error("FAIL en_while_busy observed=1 expected=0");
      end
      assert ($onehot0(req_ready)) else begin
        errors++;
        $error("FAIL ready_onehot observed=%b expected=onehot0", req_ready);
      end
      assert (dbg_state == ST_FETCH || req_ready == '0) else begin
        errors++;
        $error("FAIL ready_outside_fetch observed=%b expected=0", req_ready);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag);
    chk($sformatf("%s_len", tag), line_q.size(), exp_q.size());
    for (int i = 0; i < line_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), line_q[i], exp_q[i]);
    line_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] fb[$];
  logic [W-1:0] mb[N][$];
  int           flen[N][$];
  int           ref_last;

  task automatic add_frame(input int k);
    for (int j = 0; j < fb.size(); j++) begin
      rq[k].push_back({(j == fb.size() - 1), fb[j]});
      mb[k].push_back(fb[j]);
    end
    flen[k].push_back(fb.size());
    fb.delete();
  endtask

  // Whole frames go out in round-robin order of owners from ref_last+1.
  task automatic model_run();
    bit found;
    do begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int k;
        int n;
        k = (ref_last + i) % N;
        if (!found && flen[k].size() > 0) begin
          n = flen[k].pop_front();
          if (HDR != 0) exp_q.push_back(W'(k));
          for (int j = 0; j < n; j++) exp_q.push_back(mb[k].pop_front());
          ref_last = k;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0) &&
             (rq[3].size() == 0) && (dbg_state == ST_IDLE) && !uart_tx_busy;
    end
    chk($sformatf("%s_done", tag), done, 1);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = (strobes >= target);
    end
    chk($sformatf("%s_strobes", tag), done, 1);
  endtask

  task automatic wait_state(input string tag, input arb_state_e s, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (dbg_state == s);
    end
    chk($sformatf("%s_state", tag), done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    uart_tx_en, 0);
    chk({tag, "_data"},  uart_tx_data, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_busy"},  arb_busy, 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic flush_all();
    for (int k = 0; k < N; k++) begin
      rq[k].delete();
      mb[k].delete();
      flen[k].delete();
    end
    line_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    logic [W-1:0] b;
    resetn    = 1'b0;
    en        = '1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    ref_last  = N - 1;
    #5;
    check_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Scenario 2: every requester holds one byte 0x10+k from reset.
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      fb.push_back(W'(8'h10 + k));
      add_frame(k);
    end
    model_run();
    drive();
    wait_done("s2", 2000);
    check_line("s2");
    chk("s2_last_grant", grant_id, 3);

    // Scenario 1: requester 2 sends 0x41,0x42,0x43; also checks strobe latency.
    @(negedge clk);
    s0 = strobes;
    fb.push_back(8'h41); fb.push_back(8'h42); fb.push_back(8'h43);
    add_frame(2);
    model_run();
    drive();
    @(posedge clk); #2;
    chk("s1_lat_c1", uart_tx_en, HDR);
    @(posedge clk); #2;
    chk("s1_lat_c2", uart_tx_en, 1 - HDR);
    wait_done("s1", 2000);
    chk("s1_count", strobes - s0, 3 + HDR);
    chk("s1_grant", grant_id, 2);
    chk("s1_idle", arb_busy, 0);
    check_line("s1");

    // Scenario 3: requester 1 stalls mid-frame while requester 3 waits.
    @(negedge clk);
    s0 = strobes;
    for (int j = 0; j < 3; j++) fb.push_back(W'($urandom_range(0, 255)));
    add_frame(1);
    model_run();
    drive();
    wait_strobes("s3_first", s0 + HDR + 1, 2000);
    en[1] = 1'b0;
    drive();
    fb.push_back(W'($urandom_range(0, 255)));
    add_frame(3);
    model_run();
    drive();
    s0 = strobes;
    repeat (20000) @(posedge clk);
    #2;
    chk("s3_no_strobe", strobes, s0);
    chk("s3_grant", grant_id, 1);
    chk("s3_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("s3_ready", req_ready, 4'b0010);
    en[1] = 1'b1;
    drive();
    wait_done("s3", 3000);
    check_line("s3");

    // Scenario 4: reset during WAIT_DONE of byte 2 of a 4-byte frame.
    @(negedge clk);
    s0 = strobes;
    for (int j = 0; j < 4; j++) fb.push_back(W'($urandom_range(0, 255)));
    add_frame(0);
    drive();
    wait_strobes("s4_two", s0 + HDR + 2, 2000);
    wait_state("s4_wd", ST_WAIT_DONE, 200);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_outputs("s4_rst");
    chk("s4_partial", line_q.size(), HDR + 2);
    flush_all();
    ref_last = N - 1;
    drive();
    @(negedge clk);
    resetn = 1'b1;
    fb.push_back(8'h5A); fb.push_back(W'($urandom_range(0, 255)));
    add_frame(2);
    model_run();
    drive();
    wait_done("s4_after", 2000);
    chk("s4_grant", grant_id, 2);
    check_line("s4");

`ifdef UART_ARB_HDR_EN
    // Scenario 5: header byte carries the owner ID.
    @(negedge clk);
    fb.push_back(8'hAA);
    add_frame(3);
    for (int k = 0; k < N; k++) begin
      mb[k].delete();
      flen[k].delete();
    end
    exp_q.push_back(8'h03);
    exp_q.push_back(8'hAA);
    ref_last = 3;
    drive();
    wait_done("s5", 2000);
    check_line("s5");
`endif

    // Randomised rounds: several frames queued at once per requester.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        int nf;
        nf = int'($urandom_range(0, 2));
        for (int f = 0; f < nf; f++) begin
          int n;
          n = int'($urandom_range(1, 3));
          for (int j = 0; j < n; j++) begin
            b = W'($urandom_range(0, 255));
            fb.push_back(b);
          end
          add_frame(k);
        end
      end
      model_run();
      drive();
      wait_done($sformatf("rnd%0d", r), 8000);
      chk($sformatf("rnd%0d_grant", r), grant_id, ref_last);
      check_line($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
